// File: rtl/drum_seq_pkg.sv
// rtl/drum_seq_pkg.sv - shared types and constants for the drum step sequencer
package drum_seq_pkg;

  typedef enum logic {IDLE, RUN} seq_state_t;

  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/seq_pattern_bank.sv
// rtl/seq_pattern_bank.sv - shadow/active per-voice step patterns with copy-on-boundary
module seq_pattern_bank #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_STEPS  = 16,
  parameter int VW         = $clog2(NUM_VOICES),
  parameter int SW         = $clog2(NUM_STEPS)
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [VW-1:0]         wr_voice,
  input  logic [NUM_STEPS-1:0]  wr_data,
  input  logic                  copy,
  input  logic [SW-1:0]         step,
  output logic [NUM_VOICES-1:0] col
);

  logic [NUM_VOICES-1:0][NUM_STEPS-1:0] shadow;
  logic [NUM_VOICES-1:0][NUM_STEPS-1:0] active;

  // Matching against each legal index drops writes to non-existent voices.
  always_ff @(posedge mclk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (copy) begin
        active <= shadow;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_en && (wr_voice == VW'(v))) begin
          shadow[v] <= wr_data;
        end
      end
    end
  end

  // During a copy the column comes from the pattern about to become active,
  // so a boundary plays exactly what it latches.
  always_comb begin
    col = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      col[v] = copy ? shadow[v][step] : active[v][step];
    end
  end

endmodule

// File: rtl/drum_step_sequencer.sv
// rtl/drum_step_sequencer.sv - per-voice step pattern sequencer emitting gated trig pulses
module drum_step_sequencer
  import drum_seq_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int NUM_STEPS   = 16,
  parameter int PERIOD_BITS = 24,
  parameter int GATE_BITS   = 24
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic                          run,
  input  logic [PERIOD_BITS-1:0]        step_period,
  input  logic [GATE_BITS-1:0]          gate_len,
  input  logic                          pat_wr_en,
  input  logic [$clog2(NUM_VOICES)-1:0] pat_wr_voice,
  input  logic [NUM_STEPS-1:0]          pat_wr_data,
  output logic [NUM_VOICES-1:0]         trig,
  output logic [$clog2(NUM_STEPS)-1:0]  step_idx,
  output logic                          step_strobe
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam int SW = $clog2(NUM_STEPS);
  localparam int CW = (PERIOD_BITS > GATE_BITS) ? PERIOD_BITS : GATE_BITS;

  seq_state_t state_q, state_d;
  logic [PERIOD_BITS-1:0] tick_q, per_q, per_eff;
  logic [GATE_BITS-1:0]   gate_q, gate_eff;
  logic [SW-1:0]          step_cnt_q;
  logic [CW-1:0]          per_w, gate_w, gate_max;
  logic [NUM_VOICES-1:0]  col;
  logic                   boundary, copy;

  seq_pattern_bank #(
    .NUM_VOICES(NUM_VOICES),
    .NUM_STEPS (NUM_STEPS),
    .VW        (VW),
    .SW        (SW)
  ) u_bank (
    .mclk    (mclk),
    .rst     (rst),
    .wr_en   (pat_wr_en),
    .wr_voice(pat_wr_voice),
    .wr_data (pat_wr_data),
    .copy    (copy),
    .step    (step_cnt_q),
    .col     (col)
  );

  // Gate is clamped below P so every pulse is followed by at least one low cycle.
  always_comb begin
    per_eff  = (step_period < PERIOD_BITS'(MIN_PERIOD)) ? PERIOD_BITS'(MIN_PERIOD) : step_period;
    per_w    = CW'(per_eff);
    gate_w   = CW'(gate_len);
    gate_max = per_w - CW'(1);
    if (gate_w == '0) begin
      gate_eff = GATE_BITS'(1);
    end else if (gate_w > gate_max) begin
      gate_eff = GATE_BITS'(gate_max);
    end else begin
      gate_eff = gate_len;
    end
  end

  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    copy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
          copy    = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
        end else begin
          boundary = (tick_q == '0);
          copy     = boundary;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      per_q       <= PERIOD_BITS'(MIN_PERIOD);
      gate_q      <= '0;
      step_cnt_q  <= '0;
      trig        <= '0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_strobe <= boundary;
      if (state_q == RUN && run) begin
        if (boundary) begin
          tick_q     <= PERIOD_BITS'(1);
          per_q      <= per_eff;
          gate_q     <= gate_eff - GATE_BITS'(1);
          step_idx   <= step_cnt_q;
          step_cnt_q <= (step_cnt_q == SW'(NUM_STEPS - 1)) ? '0 : step_cnt_q + SW'(1);
          trig       <= col;
        end else begin
          tick_q <= (tick_q == per_q - PERIOD_BITS'(1)) ? '0 : tick_q + PERIOD_BITS'(1);
          if (gate_q != '0) begin
            gate_q <= gate_q - GATE_BITS'(1);
          end else begin
            trig <= '0;
          end
        end
      end else begin
        tick_q     <= '0;
        gate_q     <= '0;
        step_cnt_q <= '0;
        step_idx   <= '0;
        trig       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// tb/tb_drum_step_sequencer.sv - directed self-checking bench for drum_step_sequencer
module tb_drum_step_sequencer;

  logic        mclk = 1'b0;
  logic        rst;
  logic        run;
  logic [23:0] step_period;
  logic [23:0] gate_len;
  logic        pat_wr_en;
  logic [1:0]  pat_wr_voice;
  logic [15:0] pat_wr_data;
  logic [3:0]  trig;
  logic [3:0]  step_idx;
  logic        step_strobe;

  int errors = 0;
  int checks = 0;

  drum_step_sequencer dut (
    .mclk        (mclk),
    .rst         (rst),
    .run         (run),
    .step_period (step_period),
    .gate_len    (gate_len),
    .pat_wr_en   (pat_wr_en),
    .pat_wr_voice(pat_wr_voice),
    .pat_wr_data (pat_wr_data),
    .trig        (trig),
    .step_idx    (step_idx),
    .step_strobe (step_strobe)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge mclk);
    #1;
  endtask

  task automatic write_pat(input int voice, input logic [15:0] data);
    pat_wr_en    = 1'b1;
    pat_wr_voice = 2'(voice);
    pat_wr_data  = data;
    step_clk();
    pat_wr_en    = 1'b0;
  endtask

  // Ends just after "edge 0": the edge where run is first sampled high in IDLE.
  task automatic restart();
    run = 1'b0;
    step_clk();
    run = 1'b1;
    step_clk();
  endtask

  initial begin
    rst          = 1'b1;
    run          = 1'b0;
    step_period  = 24'd8;
    gate_len     = 24'd3;
    pat_wr_en    = 1'b0;
    pat_wr_voice = 2'd0;
    pat_wr_data  = 16'h0000;
    step_clk();
    step_clk();
    check("rst_trig", int'(trig), 0);
    check("rst_step", int'(step_idx), 0);
    check("rst_strobe", int'(step_strobe), 0);

    // Single step-0 hit on voice 0, P=8, G=3, across a full pattern wrap.
    rst = 1'b0;
    write_pat(0, 16'h0001);
    run = 1'b1;
    step_clk();
    check("t1_edge0_strobe", int'(step_strobe), 0);
    check("t1_edge0_trig", int'(trig), 0);
    for (int c = 1; c <= 140; c++) begin
      step_clk();
      check("t1_strobe", int'(step_strobe), ((c - 1) % 8 == 0) ? 1 : 0);
      check("t1_step", int'(step_idx), ((c - 1) / 8) % 16);
      check("t1_trig0", int'(trig[0]), (((c - 1) % 128) < 3) ? 1 : 0);
    end

    // All-ones voice 1, P=4, gate 10 clamps to 3 high / 1 low.
    run = 1'b0;
    write_pat(1, 16'hFFFF);
    step_period = 24'd4;
    gate_len    = 24'd10;
    restart();
    for (int c = 1; c <= 20; c++) begin
      step_clk();
      check("t2_trig1", int'(trig[1]), (((c - 1) % 4) < 3) ? 1 : 0);
      check("t2_strobe", int'(step_strobe), ((c - 1) % 4 == 0) ? 1 : 0);
    end

    // period=1 -> P=2, gate=0 -> G=1: trig alternates.
    step_period = 24'd1;
    gate_len    = 24'd0;
    restart();
    for (int c = 1; c <= 12; c++) begin
      step_clk();
      check("t3_trig1", int'(trig[1]), (c % 2 == 1) ? 1 : 0);
      check("t3_step", int'(step_idx), ((c - 1) / 2) % 16);
    end

    // Write on the step-1 boundary edge (edge 9) is too late for step 1.
    step_period = 24'd8;
    gate_len    = 24'd3;
    run = 1'b0;
    write_pat(2, 16'h0000);
    restart();
    pat_wr_voice = 2'd2;
    pat_wr_data  = 16'h0002;
    for (int c = 1; c <= 9; c++) begin
      step_clk();
      pat_wr_en = (c == 8);
    end
    check("t4_late_strobe", int'(step_strobe), 1);
    check("t4_late_step", int'(step_idx), 1);
    check("t4_late_trig2", int'(trig[2]), 0);

    // Same write one edge earlier (edge 8) lands in step 1.
    run = 1'b0;
    write_pat(2, 16'h0000);
    restart();
    pat_wr_voice = 2'd2;
    pat_wr_data  = 16'h0002;
    for (int c = 1; c <= 9; c++) begin
      step_clk();
      pat_wr_en = (c == 7);
    end
    check("t4_early_step", int'(step_idx), 1);
    check("t4_early_trig2", int'(trig[2]), 1);

    // Drop run in the 3rd cycle of the step-1 pulse, then restart from step 0.
    run = 1'b0;
    write_pat(0, 16'h0003);
    step_period = 24'd8;
    gate_len    = 24'd6;
    restart();
    for (int c = 1; c <= 11; c++) begin
      step_clk();
    end
    check("t5_pre_trig0", int'(trig[0]), 1);
    check("t5_pre_step", int'(step_idx), 1);
    run = 1'b0;
    step_clk();
    check("t5_stop_trig", int'(trig), 0);
    check("t5_stop_step", int'(step_idx), 0);
    check("t5_stop_strobe", int'(step_strobe), 0);
    run = 1'b1;
    step_clk();
    check("t5_rerun_edge0_strobe", int'(step_strobe), 0);
    step_clk();
    check("t5_rerun_strobe", int'(step_strobe), 1);
    check("t5_rerun_step", int'(step_idx), 0);
    check("t5_rerun_trig0", int'(trig[0]), 1);

    // Period 8 -> 5 during step 2: boundaries at 1, 9, 17, 25, 30, 35.
    gate_len = 24'd3;
    restart();
    for (int c = 1; c <= 36; c++) begin
      step_clk();
      if (c == 19) step_period = 24'd5;
      check("t6_strobe", int'(step_strobe),
            (c == 1 || c == 9 || c == 17 || c == 25 || c == 30 || c == 35) ? 1 : 0);
      if (c == 30) check("t6_step4", int'(step_idx), 4);
      if (c == 35) check("t6_step5", int'(step_idx), 5);
    end

    // Reset mid-run clears outputs and patterns, then run resumes with empty patterns.
    rst = 1'b1;
    step_clk();
    check("t7_rst_trig", int'(trig), 0);
    check("t7_rst_step", int'(step_idx), 0);
    check("t7_rst_strobe", int'(step_strobe), 0);
    rst = 1'b0;
    step_clk();
    step_clk();
    check("t7_after_strobe", int'(step_strobe), 1);
    check("t7_after_trig", int'(trig), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
